// File: rtl/pfb_wideband_ctrl_if.sv
// PFB-facing stream bundle: raw input beat qualifiers in, gated beat controls out.
// The master is the controller; the slave is whoever feeds the input beat and consumes the controls.
interface pfb_wideband_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  din_valid;
   logic                  sync_in;
   logic                  pfb_ovf;
   logic                  pfb_din_valid;
   logic                  pfb_sync;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic                  data_good;

   modport master (
      input  din_valid,
      input  sync_in,
      input  pfb_ovf,
      output pfb_din_valid,
      output pfb_sync,
      output beat_addr,
      output data_good
   );

   modport slave (
      output din_valid,
      output sync_in,
      output pfb_ovf,
      input  pfb_din_valid,
      input  pfb_sync,
      input  beat_addr,
      input  data_good
   );
endinterface

// File: rtl/pfb_wideband_ctrl.sv
// Arm/sync sequencer for the multi-lane wideband PFB: beat gating, fill tracking, status.
// Optional frame-count auto-stop is enabled by defining PFB_CTRL_FRAME_LIMIT_EN.
module pfb_wideband_ctrl #(
   parameter int unsigned LANES           = 4,
   parameter int unsigned PFB_SIZE        = 64,
   parameter int unsigned TAPS            = 4,
   parameter int unsigned FRAME_CNT_WIDTH = 32,
   parameter int unsigned FRAME_LIMIT     = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       arm,
   input  logic                       stop,
   input  logic                       status_clr,
   pfb_wideband_ctrl_if.master        pfb,
   output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
   output logic [1:0]                 state,
   output logic                       ovf_sticky,
   output logic                       resync_err
`ifdef PFB_CTRL_FRAME_LIMIT_EN
   ,
   output logic                       limit_done
`endif
);

   localparam int unsigned BEATS = PFB_SIZE / LANES;
   localparam int unsigned AW    = $clog2(BEATS);
   localparam int unsigned FW    = $clog2(TAPS + 1);
   localparam logic [AW-1:0] LastBeat = AW'(BEATS - 1);
   localparam logic [FW-1:0] LastFill = FW'(TAPS - 1);
   localparam logic [FW-1:0] FullFill = FW'(TAPS);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitSync = 2'd1,
      StFill     = 2'd2,
      StRun      = 2'd3
   } state_e;

   state_e        state_q;
   logic [AW-1:0] beat_q;   // index of the next beat to issue
   logic [FW-1:0] fill_q;
   logic          active;
   logic          misaligned;
   logic          frame_done;

   assign active     = (state_q == StFill) || (state_q == StRun);
   assign misaligned = active && pfb.din_valid && pfb.sync_in && (beat_q != '0);
   assign frame_done = active && pfb.din_valid && !misaligned && (beat_q == LastBeat);
   assign state      = state_q;

`ifdef PFB_CTRL_FRAME_LIMIT_EN
   logic limit_hit;
   assign limit_hit = frame_done && ((frame_cnt + 1'b1) == FRAME_CNT_WIDTH'(FRAME_LIMIT));
`else
   logic unused_cfg;
   assign unused_cfg = ^FRAME_LIMIT;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= StIdle;
         beat_q            <= '0;
         fill_q            <= '0;
         frame_cnt         <= '0;
         ovf_sticky        <= 1'b0;
         resync_err        <= 1'b0;
         pfb.pfb_din_valid <= 1'b0;
         pfb.pfb_sync      <= 1'b0;
         pfb.beat_addr     <= '0;
         pfb.data_good     <= 1'b0;
`ifdef PFB_CTRL_FRAME_LIMIT_EN
         limit_done        <= 1'b0;
`endif
      end else begin
         pfb.pfb_din_valid <= 1'b0;
         pfb.pfb_sync      <= 1'b0;
`ifdef PFB_CTRL_FRAME_LIMIT_EN
         limit_done        <= 1'b0;
`endif
         // Later set-assignments override the clear, so a same-cycle event keeps the flag.
         if (status_clr) begin
            ovf_sticky <= 1'b0;
            resync_err <= 1'b0;
         end
         if (active && pfb.pfb_ovf) ovf_sticky <= 1'b1;

         if (stop) begin
            state_q       <= StIdle;
            beat_q        <= '0;
            fill_q        <= '0;
            pfb.beat_addr <= '0;
            pfb.data_good <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (arm) begin
                     state_q   <= StWaitSync;
                     frame_cnt <= '0;
                     beat_q    <= '0;
                     fill_q    <= '0;
                  end
               end
               StWaitSync: begin
                  if (pfb.din_valid && pfb.sync_in) begin
                     state_q           <= StFill;
                     beat_q            <= AW'(1);
                     pfb.pfb_din_valid <= 1'b1;
                     pfb.pfb_sync      <= 1'b1;
                     pfb.beat_addr     <= '0;
                  end
               end
               StFill, StRun: begin
                  if (misaligned) begin
                     // Realign on the external sync; filter history is no longer coherent.
                     resync_err        <= 1'b1;
                     state_q           <= StFill;
                     beat_q            <= AW'(1);
                     fill_q            <= '0;
                     pfb.data_good     <= 1'b0;
                     pfb.pfb_din_valid <= 1'b1;
                     pfb.pfb_sync      <= 1'b1;
                     pfb.beat_addr     <= '0;
                  end else if (pfb.din_valid) begin
                     pfb.pfb_din_valid <= 1'b1;
                     pfb.pfb_sync      <= (beat_q == '0);
                     pfb.beat_addr     <= beat_q;
                     beat_q            <= (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
                     if (frame_done) begin
                        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
                        if (fill_q != FullFill) fill_q <= fill_q + 1'b1;
                        if (fill_q >= LastFill) begin
                           pfb.data_good <= 1'b1;
                           state_q       <= StRun;
                        end
`ifdef PFB_CTRL_FRAME_LIMIT_EN
                        if (limit_hit) begin
                           state_q       <= StIdle;
                           beat_q        <= '0;
                           fill_q        <= '0;
                           pfb.data_good <= 1'b0;
                           limit_done    <= 1'b1;
                        end
`endif
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pfb_wideband_ctrl.sv
// Scoreboard bench for pfb_wideband_ctrl: random stimulus against a frame-level reference model.
module tb_pfb_wideband_ctrl;
   localparam int unsigned LANES    = 4;
   localparam int unsigned PFB_SIZE = 64;
   localparam int unsigned TAPS     = 4;
   localparam int unsigned FCW      = 32;
`ifdef PFB_CTRL_FRAME_LIMIT_EN
   localparam int unsigned FRAME_LIMIT = 8;
`else
   localparam int unsigned FRAME_LIMIT = 1024;
`endif
   localparam int unsigned BEATS     = PFB_SIZE / LANES;
   localparam int unsigned AW        = $clog2(BEATS);
   localparam longint      FRAME_MAX = (64'd1 << FCW) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           arm = 1'b0;
   logic           stop = 1'b0;
   logic           status_clr = 1'b0;
   logic [FCW-1:0] frame_cnt;
   logic [1:0]     state;
   logic           ovf_sticky;
   logic           resync_err;
`ifdef PFB_CTRL_FRAME_LIMIT_EN
   logic           limit_done;
`endif

   pfb_wideband_ctrl_if #(.ADDR_WIDTH(AW)) pfb ();

   pfb_wideband_ctrl #(
      .LANES           (LANES),
      .PFB_SIZE        (PFB_SIZE),
      .TAPS            (TAPS),
      .FRAME_CNT_WIDTH (FCW),
      .FRAME_LIMIT     (FRAME_LIMIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .stop       (stop),
      .status_clr (status_clr),
      .pfb        (pfb.master),
      .frame_cnt  (frame_cnt),
      .state      (state),
      .ovf_sticky (ovf_sticky),
      .resync_err (resync_err)
`ifdef PFB_CTRL_FRAME_LIMIT_EN
      ,
      .limit_done (limit_done)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic          sync;
   } beat_t;

   typedef struct {
      logic [1:0]     st;
      logic [FCW-1:0] fc;
      logic [AW-1:0]  addr;
      logic           pdv;
      logic           good;
      logic           ovf;
      logic           rerr;
      logic           ldone;
   } cyc_t;

   beat_t beat_q[$];
   cyc_t  cyc_q[$];
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 1'b0;

   // Reference model: mode numbering follows the state output encoding.
   int     m_mode, m_pos, m_filled, m_addr;
   longint m_frames;
   bit     m_good, m_ovf, m_rerr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_filled = 0; m_addr = 0; m_frames = 0;
      m_good = 0; m_ovf = 0; m_rerr = 0;
   endtask

   task automatic model_step(input bit a, input bit s, input bit sy, input bit dv,
                             input bit ov, input bit cl);
      cyc_t  c;
      beat_t b;
      bit    act_now;
      bit    ev_rerr;
      bit    pdv;
      bit    psy;
      bit    ldone;
      act_now = (m_mode >= 2);
      ev_rerr = 0; pdv = 0; psy = 0; ldone = 0;
      if (s) begin
         m_mode = 0; m_good = 0; m_pos = 0; m_filled = 0; m_addr = 0;
      end else if (m_mode == 0) begin
         if (a) begin m_mode = 1; m_frames = 0; end
      end else if (m_mode == 1) begin
         if (dv && sy) begin pdv = 1; psy = 1; m_addr = 0; m_pos = 1; m_mode = 2; end
      end else if (dv) begin
         if (sy && m_pos != 0) begin
            ev_rerr = 1; pdv = 1; psy = 1; m_addr = 0; m_pos = 1;
            m_filled = 0; m_good = 0; m_mode = 2;
         end else begin
            pdv = 1; psy = (m_pos == 0); m_addr = m_pos;
            if (m_pos == BEATS - 1) begin
               if (m_frames < FRAME_MAX) m_frames++;
               m_filled++;
               if (m_filled >= TAPS) begin m_good = 1; m_mode = 3; end
`ifdef PFB_CTRL_FRAME_LIMIT_EN
               if (m_frames == FRAME_LIMIT) begin
                  m_mode = 0; m_good = 0; m_filled = 0; ldone = 1;
               end
`endif
            end
            m_pos = (m_pos + 1) % BEATS;
         end
      end
      m_ovf  = (act_now && ov) || (m_ovf && !cl);
      m_rerr = ev_rerr || (m_rerr && !cl);
      c.st = 2'(m_mode); c.fc = FCW'(m_frames); c.addr = AW'(m_addr); c.pdv = pdv;
      c.good = m_good; c.ovf = m_ovf; c.rerr = m_rerr; c.ldone = ldone;
      cyc_q.push_back(c);
      if (pdv) begin
         b.addr = AW'(m_addr); b.sync = psy;
         beat_q.push_back(b);
      end
   endtask

   task automatic drive(input bit a, input bit s, input bit sy, input bit dv,
                        input bit ov, input bit cl);
      @(negedge clk);
      arm = a; stop = s; pfb.sync_in = sy; pfb.din_valid = dv; pfb.pfb_ovf = ov;
      status_clr = cl;
      model_step(a, s, sy, dv, ov, cl);
      mon_en = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, 64'(state), 0);
      check({tag, "_frame_cnt"}, 64'(frame_cnt), 0);
      check({tag, "_pfb_din_valid"}, 64'(pfb.pfb_din_valid), 0);
      check({tag, "_pfb_sync"}, 64'(pfb.pfb_sync), 0);
      check({tag, "_beat_addr"}, 64'(pfb.beat_addr), 0);
      check({tag, "_data_good"}, 64'(pfb.data_good), 0);
      check({tag, "_ovf_sticky"}, 64'(ovf_sticky), 0);
      check({tag, "_resync_err"}, 64'(resync_err), 0);
   endtask

   // Monitor: compares every registered output against the oldest expectation.
   always @(posedge clk) begin
      if (mon_en) begin
         #1;
         if (cyc_q.size() == 0) begin
            check("cyc_queue_underflow", 64'(cyc_q.size()), 1);
         end else begin
            cyc_t c;
            c = cyc_q.pop_front();
            check("state", 64'(state), 64'(c.st));
            check("frame_cnt", 64'(frame_cnt), 64'(c.fc));
            check("beat_addr", 64'(pfb.beat_addr), 64'(c.addr));
            check("pfb_din_valid", 64'(pfb.pfb_din_valid), 64'(c.pdv));
            check("data_good", 64'(pfb.data_good), 64'(c.good));
            check("ovf_sticky", 64'(ovf_sticky), 64'(c.ovf));
            check("resync_err", 64'(resync_err), 64'(c.rerr));
`ifdef PFB_CTRL_FRAME_LIMIT_EN
            check("limit_done", 64'(limit_done), 64'(c.ldone));
`endif
         end
         if (pfb.pfb_din_valid) begin
            if (beat_q.size() == 0) begin
               check("unexpected_beat", 64'(beat_q.size()), 1);
            end else begin
               beat_t b;
               b = beat_q.pop_front();
               check("beat_sync", 64'(pfb.pfb_sync), 64'(b.sync));
               check("beat_addr_on_beat", 64'(pfb.beat_addr), 64'(b.addr));
            end
         end else begin
            check("sync_without_valid", 64'(pfb.pfb_sync), 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a, s, sy, dv, ov, cl;
      pfb.sync_in = 1'b0; pfb.din_valid = 1'b0; pfb.pfb_ovf = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Arm, five unsynced beats, sync on the sixth, then continuous beats through fill.
      drive(1, 0, 0, 0, 0, 0);
      repeat (5) drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      repeat (79) drive(0, 0, 0, 1, 0, 0);

      // Valid gaps.
      for (int i = 0; i < 40; i++) drive(0, 0, 0, (i % 2) == 0, 0, 0);

      // Misaligned sync at beat 7 in RUN, then clear.
      for (int i = 0; i < 100 && !(m_mode == 3 && m_pos == 7); i++) drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 1);
      repeat (70) drive(0, 0, 0, 1, 0, 0);

      // Overflow persists; clear racing an overflow keeps it; stop+arm returns to idle.
      drive(0, 0, 0, 1, 1, 0);
      repeat (3) drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 1);
      drive(0, 1, 0, 1, 0, 0);
      drive(1, 1, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 1, 0);
      drive(0, 0, 0, 0, 0, 1);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         a  = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
         s  = ($urandom_range(0, 299) == 0);
         dv = ($urandom_range(0, 3) != 0);
         if (m_mode == 1) sy = ($urandom_range(0, 9) == 0);
         else if (m_mode >= 2 && m_pos == 0) sy = ($urandom_range(0, 1) == 0);
         else sy = ($urandom_range(0, 149) == 0);
         ov = ($urandom_range(0, 99) == 0);
         cl = ($urandom_range(0, 49) == 0);
         drive(a, s, sy, dv, ov, cl);
      end

      // Asynchronous reset in the middle of RUN.
      drive(0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      repeat (70) drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 0);
      @(negedge clk);
      mon_en = 1'b0;
      arm = 0; stop = 0; pfb.sync_in = 0; pfb.din_valid = 0; pfb.pfb_ovf = 0; status_clr = 0;
      check("pre_reset_cyc_drained", 64'(cyc_q.size()), 0);
      check("pre_reset_beat_drained", 64'(beat_q.size()), 0);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset");
      cyc_q.delete();
      beat_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Restart after reset.
      drive(1, 0, 0, 1, 0, 0);
      drive(0, 0, 1, 1, 0, 0);
      repeat (20) drive(0, 0, 0, 1, 0, 0);
      @(negedge clk);
      check("final_cyc_drained", 64'(cyc_q.size()), 0);
      check("final_beat_drained", 64'(beat_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pfb_wideband_ctrl.md
Name: pfb_wideband_ctrl

Overview:
- Sequencer for the multi-lane real wideband polyphase filterbank.
- Arms on software request and aligns frame boundaries to the external sync_in.
- Drives the PFB's gated valid, frame-start sync and per-beat coefficient address.
- Tracks filter fill (TAPS frames), counts output frames, and keeps sticky overflow and misalignment status for the register bank.

Parameters:
- LANES, 4, parallel samples per beat (power of 2).
- PFB_SIZE, 64, filterbank size in samples (power of 2, ≥ 2*LANES).
- TAPS, 4, filter taps; full frames required before output is valid.
- FRAME_CNT_WIDTH, 32, width of frame counter.
- FRAME_LIMIT, 1024, frames to run before auto-stop (used only with optional feature).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle request: wait for next sync_in, then run.
- stop  in  1  one-cycle request: return to IDLE.
- sync_in  in  1  external frame-alignment pulse, qualified by din_valid.
- din_valid  in  1  input beat valid (LANES samples).
- pfb_ovf  in  1  overflow flag from the PFB.
- status_clr  in  1  clears ovf_sticky and resync_err.
- pfb_din_valid  out  1  din_valid gated by RUN/FILL state.
- pfb_sync  out  1  one-cycle pulse on the first beat of each frame.
- beat_addr  out  $clog2(PFB_SIZE/LANES)  beat index within frame (coefficient address).
- data_good  out  1  high once TAPS full frames have been issued.
- frame_cnt  out  FRAME_CNT_WIDTH  frames completed since arming; saturates.
- state  out  2  0=IDLE, 1=WAIT_SYNC, 2=FILL, 3=RUN.
- ovf_sticky  out  1  sticky OR of pfb_ovf while in FILL/RUN.
- resync_err  out  1  sticky: sync_in seen with beat_addr≠0 in FILL/RUN.

Behaviour:
- Reset: every output 0; state IDLE; internal beat and fill counters 0.
- All outputs registered; one cycle latency from inputs.
- BEATS = PFB_SIZE/LANES.

State transitions:
- IDLE: arm → WAIT_SYNC. sync_in is ignored.
- WAIT_SYNC: on din_valid & sync_in → FILL. That same beat is beat 0: pfb_sync=1, pfb_din_valid=1, beat_addr=0. Beats before the sync are dropped (pfb_din_valid=0).
- FILL/RUN beat handling: each din_valid beat asserts pfb_din_valid. beat_addr increments mod BEATS and wraps BEATS-1 → 0. pfb_sync pulses when the outgoing beat_addr=0.
- Frame completion (beat BEATS-1 issued): frame_cnt += 1, saturating at all-ones. Fill counter += 1. When it reaches TAPS: data_good=1 and FILL → RUN.
- din_valid low: counters hold; no output pulses.
- Misaligned sync (din_valid & sync_in with current beat≠0 in FILL/RUN): resync_err=1; beat_addr forced to 0 with pfb_sync=1 on that beat; fill counter cleared; data_good=0; state FILL; frame_cnt retained.
- Aligned sync (sync_in on beat 0): no effect.
- stop in any state: → IDLE next cycle. data_good=0, pfb_din_valid=0, beat counter cleared. frame_cnt retained until next arm.

Simultaneous events:
- stop & arm together: stop wins.
- arm in WAIT_SYNC, FILL or RUN: ignored.
- arm from IDLE clears frame_cnt.
- status_clr & a new ovf/resync event in the same cycle: the event wins (flag stays 1).
- pfb_ovf outside FILL/RUN: ignored.

Optional Feature:
- Macro PFB_CTRL_FRAME_LIMIT_EN.
- Defined: when frame_cnt reaches FRAME_LIMIT on a frame completion, the block returns to IDLE as if stop had been asserted. It asserts a one-cycle output port limit_done (1 bit) in that cycle.
- Undefined: the limit_done port does not exist and the block runs until stop; FRAME_LIMIT is unused.

Test Plan:
- Reset: rst_n low mid-RUN → all outputs 0 and state=0 asynchronously, before the next clk edge.
- Arm/align: arm, then 5 valid beats, then sync_in on 6th → first 5 beats give pfb_din_valid=0. 6th gives pfb_sync=1 and beat_addr=0. Continuous valid → beat_addr wraps 15→0 every 16 beats.
- Fill: defaults (TAPS=4, 16 beats) with continuous valid → data_good rises on the cycle after beat 64 is issued; state=3; frame_cnt=4.
- Valid gaps: din_valid toggling 1,0,1,0 → beat_addr advances only on valid beats; one frame takes 32 cycles.
- Misaligned sync: sync_in at beat_addr=7 in RUN → resync_err=1, beat_addr=0 with pfb_sync, data_good=0, state=2. status_clr → resync_err=0.
- Overflow and stop: pfb_ovf pulse in RUN → ovf_sticky=1 and it persists. stop+arm same cycle → state=0. PFB_CTRL_FRAME_LIMIT_EN with FRAME_LIMIT=8 → limit_done pulses after frame 8, state=0.
